// File: rtl/alu_issue_stage_if.sv
// Signal bundle of alu_issue_stage: instruction handshake, issued-operand handshake and write-back port.
// slave = the issue stage itself, master = the environment driving it.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_aluc;
    logic [ADDR_W-1:0] out_rd;
    logic              out_illegal;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, out_a, out_b, out_aluc, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_aluc, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit MIPS alu: decode, register read, busy scoreboard, registered issue.
// Optional macro ALU_ISSUE_BYPASS_EN: write-back data forwards to a source operand in the write-back cycle.
module alu_issue_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    typedef enum logic [1:0] {A_ZERO, A_RS, A_SHAMT} a_sel_e;
    typedef enum logic [1:0] {B_ZERO, B_RT, B_SEXT, B_ZEXT} b_sel_e;

    typedef struct packed {
        logic              legal;
        logic [3:0]        aluc;
        logic              rs_used;
        logic              rt_used;
        logic [ADDR_W-1:0] dest;
        a_sel_e            a_sel;
        b_sel_e            b_sel;
    } dec_t;

    localparam dec_t DEC_ILLEGAL = '{
        legal:   1'b0,
        aluc:    4'b0000,
        rs_used: 1'b0,
        rt_used: 1'b0,
        dest:    '0,
        a_sel:   A_ZERO,
        b_sel:   B_ZERO
    };

    // Instruction fields
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] src_rs;
    logic [ADDR_W-1:0] src_rt;
    logic [ADDR_W-1:0] rd_field;

    assign instr    = bus.in_instr;
    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign shamt    = instr[10:6];
    assign imm      = instr[15:0];
    assign src_rs   = ADDR_W'(instr[25:21]);
    assign src_rt   = ADDR_W'(instr[20:16]);
    assign rd_field = ADDR_W'(instr[15:11]);

    dec_t dec;

    always_comb begin
        // NOTE: the whole struct is defaulted first so no decode path can infer a latch.
        dec = DEC_ILLEGAL;
        if (opcode == 6'h00) begin
            dec.legal   = 1'b1;
            dec.rs_used = 1'b1;
            dec.rt_used = 1'b1;
            dec.dest    = rd_field;
            dec.a_sel   = A_RS;
            dec.b_sel   = B_RT;
            case (funct)
                6'h20:   dec.aluc = 4'b0010;
                6'h21:   dec.aluc = 4'b0000;
                6'h22:   dec.aluc = 4'b0011;
                6'h23:   dec.aluc = 4'b0001;
                6'h24:   dec.aluc = 4'b0100;
                6'h25:   dec.aluc = 4'b0101;
                6'h26:   dec.aluc = 4'b0110;
                6'h27:   dec.aluc = 4'b0111;
                6'h2A:   dec.aluc = 4'b1011;
                6'h2B:   dec.aluc = 4'b1010;
                6'h04:   dec.aluc = 4'b1110;
                6'h06:   dec.aluc = 4'b1101;
                6'h07:   dec.aluc = 4'b1100;
                6'h00, 6'h02, 6'h03: begin
                    // Constant shifts take the amount from shamt; rs is not a source.
                    dec.rs_used = 1'b0;
                    dec.a_sel   = A_SHAMT;
                    case (funct)
                        6'h00:   dec.aluc = 4'b1110;
                        6'h02:   dec.aluc = 4'b1101;
                        default: dec.aluc = 4'b1100;
                    endcase
                end
                default: dec.legal = 1'b0;
            endcase
        end else begin
            dec.legal   = 1'b1;
            dec.rs_used = 1'b1;
            dec.dest    = src_rt;
            dec.a_sel   = A_RS;
            case (opcode)
                6'h08:   begin dec.aluc = 4'b0010; dec.b_sel = B_SEXT; end
                6'h09:   begin dec.aluc = 4'b0000; dec.b_sel = B_SEXT; end
                6'h0A:   begin dec.aluc = 4'b1011; dec.b_sel = B_SEXT; end
                6'h0B:   begin dec.aluc = 4'b1010; dec.b_sel = B_SEXT; end
                6'h0C:   begin dec.aluc = 4'b0100; dec.b_sel = B_ZEXT; end
                6'h0D:   begin dec.aluc = 4'b0101; dec.b_sel = B_ZEXT; end
                6'h0E:   begin dec.aluc = 4'b0110; dec.b_sel = B_ZEXT; end
                6'h0F: begin
                    dec.aluc    = 4'b1000;
                    dec.rs_used = 1'b0;
                    dec.a_sel   = A_ZERO;
                    dec.b_sel   = B_ZEXT;
                end
                default: dec.legal = 1'b0;
            endcase
        end
        if (!dec.legal) begin
            dec = DEC_ILLEGAL;
        end
    end

    // Register file and scoreboard
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                byp_rs;
    logic                byp_rt;
    logic                hazard;
    logic                accept;

`ifdef ALU_ISSUE_BYPASS_EN
    assign byp_rs = bus.wb_en && (bus.wb_addr == src_rs) && (src_rs != '0);
    assign byp_rt = bus.wb_en && (bus.wb_addr == src_rt) && (src_rt != '0);
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    assign hazard = (dec.rs_used && busy[src_rs] && !byp_rs)
                 || (dec.rt_used && busy[src_rt] && !byp_rt)
                 || busy[dec.dest];

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        busy_next = busy;
        if (bus.wb_en) begin
            busy_next[bus.wb_addr] = 1'b0;
        end
        // A new claim on the same register as this cycle's write-back must win.
        if (accept && dec.dest != '0) begin
            busy_next[dec.dest] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; blocking '=' stays in always_comb.
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array is reset because zeroed registers after reset are architectural here;
        // that keeps it in flops rather than a RAM macro.
        if (rst) begin
            regs <= '{default: '0};
        end else if (bus.wb_en && bus.wb_addr != '0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Operand selection
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    assign rs_val = byp_rs ? bus.wb_data : regs[src_rs];
    assign rt_val = byp_rt ? bus.wb_data : regs[src_rt];

    always_comb begin
        a_next = '0;
        case (dec.a_sel)
            A_RS:    a_next = rs_val;
            A_SHAMT: a_next = DATA_W'(shamt);
            default: a_next = '0;
        endcase
    end

    always_comb begin
        b_next = '0;
        case (dec.b_sel)
            B_RT:    b_next = rt_val;
            B_SEXT:  b_next = {{(DATA_W-16){imm[15]}}, imm};
            B_ZEXT:  b_next = DATA_W'(imm);
            default: b_next = '0;
        endcase
    end

    // Issue register: loads on accept, holds while the alu side stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_illegal <= 1'b0;
            bus.out_a       <= '0;
            bus.out_b       <= '0;
            bus.out_aluc    <= '0;
            bus.out_rd      <= '0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_illegal <= !dec.legal;
            bus.out_a       <= a_next;
            bus.out_b       <= b_next;
            bus.out_aluc    <= dec.aluc;
            bus.out_rd      <= dec.dest;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; expected issue tuples are hand-computed per instruction word.
// Compile with or without ALU_ISSUE_BYPASS_EN to match the RTL build.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    alu_issue_stage #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {valid, illegal, aluc, rd, a, b}
    wire [74:0] obs = {bus.out_valid, bus.out_illegal, bus.out_aluc, bus.out_rd, bus.out_a, bus.out_b};

    function automatic logic [74:0] exp_out(input logic ill, input logic [3:0] aluc, input logic [4:0] rd,
                                            input logic [31:0] a, input logic [31:0] b);
        return {1'b1, ill, aluc, rd, a, b};
    endfunction

    task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        @(posedge clk); #1;
        bus.wb_en   = 1'b0;
    endtask

    // Presents a word and holds it until accepted (bounded), returning just after the accepting edge.
    task automatic send(input logic [31:0] instr);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: instr=%h in_ready=%b want 1", instr, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_reg();
        send(32'h00221821);  // addu $3,$1,$2 with zeroed regs
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd3, 32'd0, 32'd0)) begin
            errors++;
            $display("FAIL zero_read: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd3, 32'd0, 32'd0));
        end
        do_wb(5'd3, 32'd0);
        do_wb(5'd0, 32'd99);  // ignored
        send(32'h00006821);  // addu $13,$0,$0
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd13, 32'd0, 32'd0)) begin
            errors++;
            $display("FAIL wb_r0_ignored: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd13, 32'd0, 32'd0));
        end
        do_wb(5'd13, 32'd0);
    endtask

    task automatic test_rtype();
        do_wb(5'd1, 32'd5);
        do_wb(5'd2, 32'd7);
        send(32'h00221821);  // addu $3,$1,$2
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd3, 32'd5, 32'd7)) begin
            errors++;
            $display("FAIL addu: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd3, 32'd5, 32'd7));
        end
        send(32'h00226027);  // nor $12,$1,$2, back to back
        checks++;
        if (obs !== exp_out(1'b0, 4'b0111, 5'd12, 32'd5, 32'd7)) begin
            errors++;
            $display("FAIL nor: got %h want %h", obs, exp_out(1'b0, 4'b0111, 5'd12, 32'd5, 32'd7));
        end
        do_wb(5'd3, 32'd12);
        do_wb(5'd12, 32'd0);
    endtask

    task automatic test_imm();
        send(32'h2404FFFF);  // addiu $4,$0,-1
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd4, 32'd0, 32'hFFFFFFFF)) begin
            errors++;
            $display("FAIL addiu: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd4, 32'd0, 32'hFFFFFFFF));
        end
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h3404FFFF;  // ori $4 while $4 busy
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: in_ready=%b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        do_wb(5'd4, 32'hFFFFFFFF);
        send(32'h3404FFFF);
        checks++;
        if (obs !== exp_out(1'b0, 4'b0101, 5'd4, 32'd0, 32'h0000FFFF)) begin
            errors++;
            $display("FAIL ori: got %h want %h", obs, exp_out(1'b0, 4'b0101, 5'd4, 32'd0, 32'h0000FFFF));
        end
        send(32'h2829FFFE);  // slti $9,$1,-2
        checks++;
        if (obs !== exp_out(1'b0, 4'b1011, 5'd9, 32'd5, 32'hFFFFFFFE)) begin
            errors++;
            $display("FAIL slti: got %h want %h", obs, exp_out(1'b0, 4'b1011, 5'd9, 32'd5, 32'hFFFFFFFE));
        end
        send(32'h304A8000);  // andi $10,$2,0x8000
        checks++;
        if (obs !== exp_out(1'b0, 4'b0100, 5'd10, 32'd7, 32'h00008000)) begin
            errors++;
            $display("FAIL andi: got %h want %h", obs, exp_out(1'b0, 4'b0100, 5'd10, 32'd7, 32'h00008000));
        end
        do_wb(5'd4, 32'hFFFFFFFF);
        do_wb(5'd9, 32'd0);
        do_wb(5'd10, 32'd0);
    endtask

    task automatic test_shift();
        send(32'h00022900);  // sll $5,$2,4
        checks++;
        if (obs !== exp_out(1'b0, 4'b1110, 5'd5, 32'd4, 32'd7)) begin
            errors++;
            $display("FAIL sll: got %h want %h", obs, exp_out(1'b0, 4'b1110, 5'd5, 32'd4, 32'd7));
        end
        send(32'h3C061234);  // lui $6,0x1234
        checks++;
        if (obs !== exp_out(1'b0, 4'b1000, 5'd6, 32'd0, 32'h00001234)) begin
            errors++;
            $display("FAIL lui: got %h want %h", obs, exp_out(1'b0, 4'b1000, 5'd6, 32'd0, 32'h00001234));
        end
        send(32'h00225807);  // srav $11,$2,$1
        checks++;
        if (obs !== exp_out(1'b0, 4'b1100, 5'd11, 32'd5, 32'd7)) begin
            errors++;
            $display("FAIL srav: got %h want %h", obs, exp_out(1'b0, 4'b1100, 5'd11, 32'd5, 32'd7));
        end
        do_wb(5'd5, 32'd0);
        do_wb(5'd6, 32'd0);
        do_wb(5'd11, 32'd0);
    endtask

    task automatic test_illegal();
        send(32'hFC000000);
        checks++;
        if (obs !== exp_out(1'b1, 4'b0000, 5'd0, 32'd0, 32'd0)) begin
            errors++;
            $display("FAIL illegal_op: got %h want %h", obs, exp_out(1'b1, 4'b0000, 5'd0, 32'd0, 32'd0));
        end
        send(32'h00221801);  // unsupported funct, rd field 3
        checks++;
        if (obs !== exp_out(1'b1, 4'b0000, 5'd0, 32'd0, 32'd0)) begin
            errors++;
            $display("FAIL illegal_funct: got %h want %h", obs, exp_out(1'b1, 4'b0000, 5'd0, 32'd0, 32'd0));
        end
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00621823;  // subu $3,$3,$2: $3 must not be busy
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_no_busy: in_ready=%b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_hazard();
        send(32'h00221821);  // addu $3,$1,$2
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00613823;  // subu $7,$3,$1
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall0: in_ready=%b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall1: in_ready=%b out_valid=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd3;
        bus.wb_data = 32'h00000C0C;
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_wb_cycle: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.wb_en    = 1'b0;
        bus.in_valid = 1'b0;
`else
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_wb_cycle: in_ready=%b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.wb_en = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_after_wb: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`endif
        checks++;
        if (obs !== exp_out(1'b0, 4'b0001, 5'd7, 32'h00000C0C, 32'd5)) begin
            errors++;
            $display("FAIL subu_raw: got %h want %h", obs, exp_out(1'b0, 4'b0001, 5'd7, 32'h00000C0C, 32'd5));
        end
        do_wb(5'd7, 32'd0);
        // Claim and write-back of $3 in the same cycle: the claim survives.
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'd12;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00221821;
        @(posedge clk); #1;
        bus.wb_en    = 1'b0;
        bus.in_instr = 32'h00613823;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: in_ready=%b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        do_wb(5'd3, 32'd12);
    endtask

    task automatic test_stall_reset();
        bus.out_ready = 1'b0;
        send(32'h00224021);  // addu $8,$1,$2
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd8, 32'd5, 32'd7)) begin
            errors++;
            $display("FAIL hold_load: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd8, 32'd5, 32'd7));
        end
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00414825;  // or $9,$2,$1 against a full output
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: in_ready=%b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd8, 32'd5, 32'd7)) begin
            errors++;
            $display("FAIL hold_keep: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd8, 32'd5, 32'd7));
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 75'd0) begin
            errors++;
            $display("FAIL stall_reset: got %h want 0", obs);
        end
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h01005021;  // addu $10,$8,$0: $8 busy before reset
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_cleared: in_ready=%b want 1", bus.in_ready);
        end
        send(32'h01005021);
        checks++;
        if (obs !== exp_out(1'b0, 4'b0000, 5'd10, 32'd0, 32'd0)) begin
            errors++;
            $display("FAIL post_reset_issue: got %h want %h", obs, exp_out(1'b0, 4'b0000, 5'd10, 32'd0, 32'd0));
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_rtype();
        test_imm();
        test_shift();
        test_illegal();
        test_hazard();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
